systolic_array_2x2: RTL and testbench
=====================================

SYSTOLIC_ARRAY_2X2 -- requirements
Module: systolic_array_2x2

Interface
REQ-001 SHALL have parameter DATA_W, default 8, meaning operand width in bits, two's complement.
REQ-002 SHALL have parameter RES_W, default 16, meaning result width in bits; results wrap modulo 2^RES_W.
REQ-003 clk  input  1  single clock; all state changes on the rising edge.
REQ-004 reset  input  1  reset; synchronous and active-high.
REQ-005 in_valid  input  1  an operand byte is present on in_data.
REQ-006 in_data  input  8  operand byte.
REQ-007 in_ready  output  1  block accepts an operand byte this cycle.
REQ-008 out_valid  output  1  a result byte is present on out_data.
REQ-009 out_data  output  8  result byte.
REQ-010 out_ready  input  1  consumer accepts the result byte this cycle.
REQ-011 busy  output  1  high in COMPUTE and DRAIN.

Function
REQ-012 SHALL compute C = A x B for signed 2x2 matrices A and B, using a 2x2 output-stationary systolic array of processing elements.
REQ-013 SHALL implement an FSM with states LOAD, COMPUTE and DRAIN.
REQ-014 SHALL leave LOAD only on the 8th accepted byte, going to COMPUTE.
REQ-015 SHALL leave COMPUTE after exactly 4 cycles, going to DRAIN.
REQ-016 SHALL leave DRAIN on the 8th accepted result byte, going to LOAD.
REQ-017 SHALL define a byte transfer as valid&&ready high on the same rising edge, in both directions.
REQ-018 SHALL drive in_ready high only in LOAD, and SHALL ignore in_data/in_valid in all other states.
REQ-019 SHALL accept input bytes in order A00, A01, A10, A11, B00, B01, B10, B11; gaps in in_valid stall the byte counter.
REQ-020 SHALL clear all accumulators and edge pipelines on the cycle of entry to COMPUTE.
REQ-021 SHALL apply edge inputs at COMPUTE step t=0..3 as follows:
- row i left input = A[i][t-i];
- column j top input = B[t-j][j];
- the value is 0 when the index falls outside 0..1.
REQ-022 SHALL make each PE register a right and b down with 1-cycle latency, and accumulate acc += a_in*b_in on every COMPUTE step.
REQ-023 SHALL use a full-precision 16-bit signed product and RES_W-bit wrapping accumulation.
REQ-024 SHALL drive out_valid high only in DRAIN, emitting C00, C01, C10, C11, each low byte first, then high byte.
REQ-025 SHALL hold out_data and out_valid stable while out_valid && !out_ready.
REQ-026 SHALL time the first out_valid exactly 5 cycles after the rising edge that accepts B11.
REQ-027 SHALL, after the final result handshake, enter LOAD with in_ready high on the next cycle; there is no same-cycle overlap of load and drain.

Reset
REQ-028 SHALL, with reset high at a rising edge, enter LOAD, zero the byte counters, step counter, operand registers and accumulators, and drive:
- out_valid=0, out_data=0, busy=0;
- in_ready=1 from the first cycle after reset.
REQ-029 SHALL give reset priority over any handshake on the same edge, and a reset mid-LOAD, mid-COMPUTE or mid-DRAIN SHALL discard all partial data.

Structure
REQ-030 SHALL place the state enum (LOAD/COMPUTE/DRAIN), DATA_W/RES_W defaults, and the operand and result byte counts (8, 8) in a shared package systolic_pkg.
REQ-031 SHALL instantiate sub-module systolic_pe four times.
REQ-032 systolic_pe SHALL provide ports a_in, b_in, a_out, b_out, clear, en and acc.

Verification
REQ-033 Identity test: A=[1,0;0,1], B=[5,6;7,8], no stalls -> out bytes 05,00,06,00,07,00,08,00; first out_valid 5 cycles after B11 accepted.
REQ-034 Signed test: A=[-1,2;3,-4], B=[5,-6;7,8] -> C=[9,22;-13,-50] -> bytes 09,00,16,00,F3,FF,CE,FF.
REQ-035 Wrap test: all A and B entries 0x80 (-128) -> each C=32768 wraps -> bytes 00,80 repeated 4 times.
REQ-036 Backpressure test: out_ready toggling 1,0,0,1 during DRAIN and in_valid gaps during LOAD -> identical byte sequence to REQ-033; out_data stable while stalled.
REQ-037 Reset test: reset asserted after 5 bytes loaded, then one full valid 8-byte matrix pair -> results reflect only the post-reset bytes.
REQ-038 Mid-run reset test: reset asserted in DRAIN after 3 result bytes -> next cycle out_valid=0, busy=0, in_ready=1.

Source files
------------

// File: rtl/systolic_pkg.sv
// Shared types and sizing for the 2x2 output-stationary systolic matrix multiplier.
package systolic_pkg;

  typedef enum logic [1:0] {
    ST_LOAD    = 2'd0,
    ST_COMPUTE = 2'd1,
    ST_DRAIN   = 2'd2
  } state_e;

  localparam int DATA_W_DEF   = 8;
  localparam int RES_W_DEF    = 16;
  localparam int N_OPER_BYTES = 8;
  localparam int N_RES_BYTES  = 8;
  localparam int N_STEPS      = 4;

endpackage

// File: rtl/systolic_pe.sv
// Output-stationary processing element: forwards a right and b down one cycle later
// and accumulates their product in place.
module systolic_pe
  import systolic_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int RES_W  = RES_W_DEF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clear,
  input  logic                     en,
  input  logic signed [DATA_W-1:0] a_in,
  input  logic signed [DATA_W-1:0] b_in,
  output logic signed [DATA_W-1:0] a_out,
  output logic signed [DATA_W-1:0] b_out,
  output logic        [RES_W-1:0]  acc
);

  logic signed [DATA_W-1:0]   a_q, b_q;
  logic        [RES_W-1:0]    acc_q;
  logic signed [2*DATA_W-1:0] prod;

  assign prod = a_in * b_in;

  // The sized cast keeps the product's sign, so it is sign-extended before the wrapping add.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      a_q   <= '0;
      b_q   <= '0;
      acc_q <= '0;
    end else if (en) begin
      a_q   <= a_in;
      b_q   <= b_in;
      acc_q <= acc_q + RES_W'(prod);
    end
  end

  assign a_out = a_q;
  assign b_out = b_q;
  assign acc   = acc_q;

endmodule

// File: rtl/systolic_array_2x2.sv
// 2x2 signed matrix multiplier: byte-stream load of A then B, four systolic steps,
// then a byte-stream drain of C (low byte first).
module systolic_array_2x2
  import systolic_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int RES_W  = RES_W_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       in_ready,
  output logic       out_valid,
  output logic [7:0] out_data,
  input  logic       out_ready,
  output logic       busy
);

  state_e                   state_q;
  logic [2:0]               in_cnt_q, out_cnt_q;
  logic [1:0]               step_q;
  logic signed [DATA_W-1:0] a_q [4];
  logic signed [DATA_W-1:0] b_q [4];
  logic                     in_ready_q, busy_q, out_valid_q;
  logic [7:0]               out_data_q;

  logic signed [DATA_W-1:0] edge_a [2];
  logic signed [DATA_W-1:0] edge_b [2];
  logic signed [DATA_W-1:0] a_mid [2];
  logic signed [DATA_W-1:0] b_mid [2];
  logic signed [DATA_W-1:0] a_tail_unused [2];
  logic signed [DATA_W-1:0] b_tail_unused [2];
  logic [RES_W-1:0]         acc_w [4];

  logic                     pe_clear, pe_en;
  logic [2:0]               drain_idx;
  logic [RES_W-1:0]         drain_acc;
  logic [7:0]               drain_byte;

  assign pe_clear = (state_q == ST_LOAD);
  assign pe_en    = (state_q == ST_COMPUTE);

  // Skewed edge feed: row i gets A[i][t-i], column j gets B[t-j][j], zero outside the matrix.
  always_comb begin
    edge_a[0] = '0;
    edge_a[1] = '0;
    edge_b[0] = '0;
    edge_b[1] = '0;
    case (step_q)
      2'd0: begin
        edge_a[0] = a_q[0];
        edge_b[0] = b_q[0];
      end
      2'd1: begin
        edge_a[0] = a_q[1];
        edge_a[1] = a_q[2];
        edge_b[0] = b_q[2];
        edge_b[1] = b_q[1];
      end
      2'd2: begin
        edge_a[1] = a_q[3];
        edge_b[1] = b_q[3];
      end
      default: ;
    endcase
  end

  systolic_pe #(.DATA_W(DATA_W), .RES_W(RES_W)) u_pe00 (
    .clk(clk), .reset(reset), .clear(pe_clear), .en(pe_en),
    .a_in(edge_a[0]), .b_in(edge_b[0]),
    .a_out(a_mid[0]), .b_out(b_mid[0]), .acc(acc_w[0])
  );
  systolic_pe #(.DATA_W(DATA_W), .RES_W(RES_W)) u_pe01 (
    .clk(clk), .reset(reset), .clear(pe_clear), .en(pe_en),
    .a_in(a_mid[0]), .b_in(edge_b[1]),
    .a_out(a_tail_unused[0]), .b_out(b_mid[1]), .acc(acc_w[1])
  );
  systolic_pe #(.DATA_W(DATA_W), .RES_W(RES_W)) u_pe10 (
    .clk(clk), .reset(reset), .clear(pe_clear), .en(pe_en),
    .a_in(edge_a[1]), .b_in(b_mid[0]),
    .a_out(a_mid[1]), .b_out(b_tail_unused[0]), .acc(acc_w[2])
  );
  systolic_pe #(.DATA_W(DATA_W), .RES_W(RES_W)) u_pe11 (
    .clk(clk), .reset(reset), .clear(pe_clear), .en(pe_en),
    .a_in(a_mid[1]), .b_in(b_mid[1]),
    .a_out(a_tail_unused[1]), .b_out(b_tail_unused[1]), .acc(acc_w[3])
  );

  // Index of the byte to present next: byte 0 when priming, otherwise the one after the current.
  assign drain_idx  = out_valid_q ? (out_cnt_q + 3'd1) : 3'd0;
  assign drain_acc  = acc_w[drain_idx[2:1]];
  assign drain_byte = drain_idx[0] ? 8'(drain_acc >> 8) : 8'(drain_acc);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_LOAD;
      in_cnt_q    <= '0;
      out_cnt_q   <= '0;
      step_q      <= '0;
      for (int k = 0; k < 4; k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
      end
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      case (state_q)
        ST_LOAD: begin
          if (in_valid && in_ready_q) begin
            if (in_cnt_q[2]) b_q[in_cnt_q[1:0]] <= DATA_W'($signed(in_data));
            else             a_q[in_cnt_q[1:0]] <= DATA_W'($signed(in_data));
            if (in_cnt_q == 3'(N_OPER_BYTES - 1)) begin
              state_q    <= ST_COMPUTE;
              in_cnt_q   <= '0;
              step_q     <= '0;
              in_ready_q <= 1'b0;
              busy_q     <= 1'b1;
            end else begin
              in_cnt_q <= in_cnt_q + 3'd1;
            end
          end
        end
        ST_COMPUTE: begin
          step_q <= step_q + 2'd1;
          if (step_q == 2'(N_STEPS - 1)) begin
            state_q   <= ST_DRAIN;
            out_cnt_q <= '0;
          end
        end
        ST_DRAIN: begin
          // First DRAIN cycle registers byte 0; afterwards advance on each handshake.
          if (!out_valid_q) begin
            out_valid_q <= 1'b1;
            out_data_q  <= drain_byte;
          end else if (out_ready) begin
            if (out_cnt_q == 3'(N_RES_BYTES - 1)) begin
              state_q     <= ST_LOAD;
              out_cnt_q   <= '0;
              out_valid_q <= 1'b0;
              out_data_q  <= '0;
              in_ready_q  <= 1'b1;
              busy_q      <= 1'b0;
            end else begin
              out_cnt_q  <= out_cnt_q + 3'd1;
              out_data_q <= drain_byte;
            end
          end
        end
        default: state_q <= ST_LOAD;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign busy      = busy_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

endmodule

// File: tb/tb_systolic_array_2x2.sv
// Scoreboard bench for systolic_array_2x2: directed matrix pairs with hand-computed result bytes.
module tb_systolic_array_2x2;

  logic       clk = 1'b0;
  logic       reset, in_valid, in_ready, out_valid, out_ready, busy;
  logic [7:0] in_data, out_data;

  int         n_tests = 0;
  int         n_fail  = 0;
  int         cyc     = 0;
  logic [7:0] exp_q [$];
  logic [7:0] exp_b;
  logic       hold_pending = 1'b0;
  logic [7:0] hold_data;

  systolic_array_2x2 dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  // Monitor: compares every accepted result byte and checks stability while stalled.
  always @(negedge clk) begin
    if (reset) begin
      hold_pending = 1'b0;
    end else begin
      if (hold_pending) begin
        check("hold_valid", 32'(out_valid), 32'd1);
        check("hold_data", 32'(out_data), 32'(hold_data));
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_out: got %0h required no byte", out_data);
        end else begin
          exp_b = exp_q.pop_front();
          check("out_byte", 32'(out_data), 32'(exp_b));
        end
      end
      hold_pending = out_valid && !out_ready;
      hold_data    = out_data;
    end
  end

  // Sends the first n bytes of v (MSB byte first); with gaps, idles i%3 cycles before byte i.
  task automatic load_pair(input logic [63:0] v, input int gaps, input int n, output int acc_cyc);
    logic rdy;
    int   w;
    acc_cyc = cyc;
    for (int i = 0; i < n; i++) begin
      if (gaps != 0) begin
        repeat (i % 3) begin
          in_valid = 1'b0;
          @(posedge clk); #1;
        end
      end
      in_valid = 1'b1;
      in_data  = v[63-8*i -: 8];
      w = 0;
      do begin
        @(negedge clk);
        rdy = in_ready;
        @(posedge clk); #1;
        w++;
      end while (!rdy && w < 20);
      if (!rdy) begin
        n_tests++;
        n_fail++;
        $display("FAIL load_timeout: got in_ready 0 required 1 (byte %0d)", i);
      end
    end
    in_valid = 1'b0;
    acc_cyc  = cyc;
  endtask

  task automatic run_pair(input string name, input logic [63:0] v, input logic [63:0] exp,
                          input int stress, input int stop_after);
    int         ac;
    int         k;
    int         w;
    logic       hit;
    logic [3:0] pat = 4'b1001;
    for (int i = 0; i < 8; i++) exp_q.push_back(exp[63-8*i -: 8]);
    load_pair(v, stress, 8, ac);
    check({name, "_busy"}, 32'(busy), 32'd1);
    check({name, "_in_ready_low"}, 32'(in_ready), 32'd0);
    in_valid  = 1'b1;
    in_data   = 8'hAA;
    out_ready = 1'b0;
    hit = 1'b0;
    for (int n = 0; n < 20 && !hit; n++) begin
      @(negedge clk);
      if (out_valid) hit = 1'b1;
    end
    check({name, "_latency"}, hit ? 32'(cyc - ac) : 32'd999, 32'd5);
    @(posedge clk); #1;
    in_valid = 1'b0;
    k = 0;
    w = 0;
    while (exp_q.size() > 0 && w < 200) begin
      out_ready = (stress != 0) ? pat[k % 4] : 1'b1;
      k++;
      w++;
      @(posedge clk); #1;
      if (stop_after > 0 && exp_q.size() == 8 - stop_after) break;
    end
    if (w >= 200) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s_drain_timeout: got %0d bytes left required 0", name, exp_q.size());
    end
    if (stop_after == 0) begin
      check({name, "_in_ready_after"}, 32'(in_ready), 32'd1);
      check({name, "_out_valid_after"}, 32'(out_valid), 32'd0);
      check({name, "_busy_after"}, 32'(busy), 32'd0);
    end
    out_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int ac;
    reset = 1'b1; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);

    run_pair("identity", 64'h01000001_05060708, 64'h05000600_07000800, 0, 0);
    run_pair("signed",   64'hFF0203FC_05FA0708, 64'h09001600_F3FFCEFF, 0, 0);
    run_pair("wrap",     64'h80808080_80808080, 64'h00800080_00800080, 0, 0);
    run_pair("backpr",   64'h01000001_05060708, 64'h05000600_07000800, 1, 0);

    // Reset after a partial load: only the following full pair may show up in the results.
    load_pair(64'h7F7F7F7F_7F7F7F7F, 0, 5, ac);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("partial_rst_in_ready", 32'(in_ready), 32'd1);
    run_pair("post_rst", 64'h02030405_01000001, 64'h02000300_04000500, 0, 0);

    // Reset in the middle of draining after three result bytes.
    run_pair("midrst", 64'hFF0203FC_05FA0708, 64'h09001600_F3FFCEFF, 0, 3);
    reset = 1'b1;
    @(posedge clk); #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    exp_q.delete();
    reset = 1'b0;
    run_pair("recover", 64'h01000001_05060708, 64'h05000600_07000800, 0, 0);

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
